uart_tx_port: RTL and testbench

Memory-mapped serial transmitter on the CPU output-port bus, downstream of the processor's OUT_PORT/PORT_ID/IO_STRB outputs. OUT writes to a data port go into a small FIFO, which drains as 8N1 frames on a single TX line. A status byte feeds the top-level IN_PORT mux. An optional level interrupt, ANDed with the CPU I flag at the top level, signals that the transmitter has drained.

---
 rtl/uart_tx_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_port.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_port.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - tx_state_t     : transmitter FSM state encoding
//   - STAT_*         : bit positions inside the status byte
//   - CTRL_*         : bit positions inside the control byte
//   - DEF_TX_*_ID    : default CPU port addresses
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // status byte layout
    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 4;

    // control byte layout
    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 3;

    localparam logic [7:0] DEF_TX_DATA_ID = 8'h40;
    localparam logic [7:0] DEF_TX_CTRL_ID = 8'h41;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with show-ahead read data.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push, din       : write request and data (ignored while full)
//   pop             : read request (ignored while empty); dout is the head entry
//   flush           : empties the FIFO; takes priority over push and pop
//   count           : number of stored entries, 0..DEPTH
//   full, empty     : derived from count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // fullness is judged on the registered count, so a push into a full
    // FIFO is dropped even if a pop happens in the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port
// CPU output-port mapped 8N1 serial transmitter with a small TX FIFO.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   port_id    : CPU port address
//   out_port   : CPU write data
//   io_strb    : write strobe, one write per high cycle
//   stat_out   : registered status {count[3:0], overflow, busy, empty, full}
//   tx         : registered serial line, idle high
//   tx_irq     : registered level interrupt, irq_en & drained
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (0) for BAUD_DIV cycles
// DATA  | 8 data bits, LSB first, BAUD_DIV cycles each
// STOP  | stop bit (1); chains straight into START if more bytes queued
module uart_tx_port
    import uart_tx_pkg::*;
#(
    parameter int         BAUD_DIV   = 434,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] TX_DATA_ID = DEF_TX_DATA_ID,
    parameter logic [7:0] TX_CTRL_ID = DEF_TX_CTRL_ID
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       io_strb,
    output logic [7:0] stat_out,
    output logic       tx,
    output logic       tx_irq
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     state;
    tx_state_t     state_n;
    logic [BW-1:0] baud_cnt;
    logic          last_tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic          irq_en;
    logic          overflow;
    logic          drained;

    logic          data_wr;
    logic          ctrl_wr;
    logic          flush;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    logic          load_shift;
    logic          shift_adv;
    logic          set_drained;
    logic [7:0]    stat_next;

    // control bits 2 and 7:4 have no function
    logic          unused_ctrl_bits;
    assign unused_ctrl_bits = &{1'b0, out_port[7:4], out_port[2]};

    assign data_wr   = io_strb && (port_id == TX_DATA_ID);
    assign ctrl_wr   = io_strb && (port_id == TX_CTRL_ID);
    assign flush     = ctrl_wr && out_port[CTRL_FLUSH];
    assign last_tick = (baud_cnt == BW'(BAUD_DIV - 1));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_wr),
        .pop   (fifo_pop),
        .flush (flush),
        .din   (out_port),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_n     = state;
        fifo_pop    = 1'b0;
        load_shift  = 1'b0;
        shift_adv   = 1'b0;
        set_drained = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load_shift = 1'b1;
                    state_n    = START;
                end
            end
            START: begin
                if (last_tick)
                    state_n = DATA;
            end
            DATA: begin
                if (last_tick) begin
                    shift_adv = 1'b1;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                end
            end
            STOP: begin
                if (last_tick) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        load_shift = 1'b1;
                        state_n    = START;
                    end else begin
                        set_drained = 1'b1;
                        state_n     = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        stat_next = '0;
        stat_next[STAT_FULL]  = fifo_full;
        stat_next[STAT_EMPTY] = fifo_empty;
        stat_next[STAT_BUSY]  = (state != IDLE);
        stat_next[STAT_OVF]   = overflow;
        stat_next[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_irq   <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            drained  <= 1'b0;
            stat_out <= 8'h02;
        end else begin
            state <= state_n;

            // restarts on every state entry so each bit is exactly BAUD_DIV cycles
            if ((state_n != state) || (state == IDLE) || last_tick)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state == START)
                bit_idx <= '0;
            else if (shift_adv)
                bit_idx <= bit_idx + 1'b1;

            if (load_shift)
                shift <= fifo_dout;
            else if (shift_adv)
                shift <= {1'b0, shift[7:1]};

            // tx follows the state register, one cycle behind it
            unique case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
                default: tx <= 1'b1;
            endcase

            if (ctrl_wr)
                irq_en <= out_port[CTRL_IRQ_EN];

            if (data_wr && fifo_full)
                overflow <= 1'b1;
            else if (ctrl_wr && out_port[CTRL_CLR_OVF])
                overflow <= 1'b0;

            // a CPU write in the same cycle as the end of the stop bit wins
            if (data_wr || ctrl_wr)
                drained <= 1'b0;
            else if (set_drained)
                drained <= 1'b1;

            tx_irq   <= irq_en && drained;
            stat_out <= stat_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port
// Directed bench for uart_tx_port with BAUD_DIV=4, FIFO_DEPTH=8.
// A monitor decodes frames on tx and compares them with a scoreboard of
// bytes queued when the writes were driven.
module tb_uart_tx_port;

    localparam int BAUD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       io_strb;
    logic [7:0] stat_out;
    logic       tx;
    logic       tx_irq;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         wr_cyc = 0;
    bit         mon_en = 1'b0;
    logic [7:0] sb[$];
    int         start_q[$];

    uart_tx_port #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (8),
        .TX_DATA_ID (8'h40),
        .TX_CTRL_ID (8'h41)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .port_id  (port_id),
        .out_port (out_port),
        .io_strb  (io_strb),
        .stat_out (stat_out),
        .tx       (tx),
        .tx_irq   (tx_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        @(negedge clk);
        port_id  = id;
        out_port = d;
        io_strb  = 1'b1;
        @(negedge clk);
        io_strb  = 1'b0;
        wr_cyc   = cyc;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n = 0;
        while (!(stat_out === 8'h02 && tx === 1'b1) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < maxc), 1);
    endtask

    // frame monitor: samples each bit in the middle of its BAUD-cycle window
    initial begin
        logic [7:0] d;
        logic [7:0] exp_b;
        int         st;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                st = cyc;
                repeat (BAUD / 2) @(negedge clk);
                chk("start_bit", 32'(tx), 0);
                for (int k = 0; k < 8; k++) begin
                    repeat (BAUD) @(negedge clk);
                    d[k] = tx;
                end
                repeat (BAUD) @(negedge clk);
                chk("stop_bit", 32'(tx), 1);
                start_q.push_back(st);
                chk("sb_has_entry", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_b = sb.pop_front();
                    chk("frame_data", 32'(d), 32'(exp_b));
                end
            end
        end
    end

    initial begin
        bit bad;
        int w0;
        reset    = 1'b1;
        io_strb  = 1'b0;
        port_id  = 8'h00;
        out_port = 8'h00;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // reset state and quiet idle
        chk("reset_stat", 32'(stat_out), 32'h02);
        chk("reset_tx", 32'(tx), 1);
        chk("reset_irq", 32'(tx_irq), 0);
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (stat_out !== 8'h02 || tx !== 1'b1 || tx_irq !== 1'b0) bad = 1'b1;
        end
        chk("idle_100", 32'(bad), 0);

        // single byte: latency, status pipeline, frame length
        start_q.delete();
        sb.push_back(8'hA5);
        wr(8'h40, 8'hA5);
        chk("tx_high_at_write", 32'(tx), 1);
        chk("stat_before_push", 32'(stat_out), 32'h02);
        @(negedge clk);
        chk("tx_high_n1", 32'(tx), 1);
        chk("stat_after_push", 32'(stat_out), 32'h10);
        @(negedge clk);
        chk("tx_fall_n2", 32'(tx), 0);
        chk("stat_after_pop", 32'(stat_out), 32'h06);
        bad = 1'b0;
        repeat (39) begin
            @(negedge clk);
            if (stat_out[2] !== 1'b1) bad = 1'b1;
        end
        chk("busy_throughout", 32'(bad), 0);
        chk("stop_last_tx", 32'(tx), 1);
        @(negedge clk);
        chk("idle_after_40", 32'(stat_out), 32'h02);
        chk("sb_empty_single", 32'(sb.size()), 0);
        chk("start_latency", (start_q.size() > 0) ? 32'(start_q[0] - wr_cyc) : 32'hFFFF_FFFF, 2);

        // three consecutive writes: back-to-back frames
        start_q.delete();
        sb.push_back(8'h01);
        sb.push_back(8'h02);
        sb.push_back(8'h03);
        @(negedge clk);
        port_id  = 8'h40;
        out_port = 8'h01;
        io_strb  = 1'b1;
        @(negedge clk);
        w0       = cyc;
        out_port = 8'h02;
        @(negedge clk);
        out_port = 8'h03;
        @(negedge clk);
        io_strb  = 1'b0;
        @(negedge clk);
        chk("count2_after_pop", 32'(stat_out), 32'h24);
        wait_idle("three_drain", 200);
        chk("three_frames", 32'(start_q.size()), 3);
        if (start_q.size() == 3) begin
            chk("three_start0", 32'(start_q[0] - w0), 2);
            chk("three_gap1", 32'(start_q[1] - start_q[0]), 40);
            chk("three_gap2", 32'(start_q[2] - start_q[1]), 40);
        end
        chk("sb_empty_three", 32'(sb.size()), 0);

        // overflow: ten consecutive writes, the tenth is dropped
        @(negedge clk);
        port_id = 8'h40;
        io_strb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            out_port = 8'h10 + 8'(i);
            if (i < 9) sb.push_back(8'h10 + 8'(i));
            @(negedge clk);
        end
        io_strb = 1'b0;
        @(negedge clk);
        chk("overflow_stat", 32'(stat_out), 32'h8D);
        wr(8'h41, 8'h08);
        @(negedge clk);
        chk("overflow_cleared", 32'(stat_out), 32'h85);
        wait_idle("overflow_drain", 500);
        chk("sb_empty_overflow", 32'(sb.size()), 0);
        chk("irq_off_when_disabled", 32'(tx_irq), 0);

        // interrupt on drain
        wr(8'h41, 8'h01);
        @(negedge clk);
        chk("irq_en_cleared_drained", 32'(tx_irq), 0);
        sb.push_back(8'h5A);
        wr(8'h40, 8'h5A);
        repeat (41) @(negedge clk);
        chk("irq_low_in_stop", 32'(tx_irq), 0);
        @(negedge clk);
        chk("irq_rise", 32'(tx_irq), 1);
        sb.push_back(8'hC3);
        wr(8'h40, 8'hC3);
        chk("irq_hold_write_edge", 32'(tx_irq), 1);
        @(negedge clk);
        chk("irq_drop", 32'(tx_irq), 0);
        wait_idle("irq_drain", 100);
        chk("irq_again", 32'(tx_irq), 1);
        wr(8'h41, 8'h00);
        @(negedge clk);
        chk("irq_disabled", 32'(tx_irq), 0);
        chk("sb_empty_irq", 32'(sb.size()), 0);

        // reset in the middle of a data bit with three bytes queued
        mon_en = 1'b0;
        @(negedge clk);
        port_id  = 8'h40;
        io_strb  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            out_port = 8'h00 + 8'(i * 8'h11);
            @(negedge clk);
        end
        io_strb = 1'b0;
        @(negedge clk);
        chk("queued3", 32'(stat_out), 32'h34);
        repeat (10) @(negedge clk);
        chk("mid_data_low", 32'(tx), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_tx", 32'(tx), 1);
        chk("midreset_stat", 32'(stat_out), 32'h02);
        chk("midreset_irq", 32'(tx_irq), 0);
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (stat_out !== 8'h02 || tx !== 1'b1) bad = 1'b1;
        end
        chk("no_frames_after_reset", 32'(bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
